fetch_pc_unit: RTL and testbench

- F-stage program-counter unit of the 5-stage MIPS pipeline; sits directly upstream of the instruction memory.
- Holds the architectural fetch PC and selects the next PC from sequential, branch/jump, exception-entry and eret sources.
- Drives the word-fetch address into instruction memory; flags fetch address errors (AdEL) and delay-slot status for the F/D pipeline register.

---
 rtl/fetch_pc_unit_pkg.sv | 23 ++
 rtl/fetch_pc_unit_addr_check.sv | 32 +++
 rtl/fetch_pc_unit.sv | 104 ++++++++++
 tb/tb_fetch_pc_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// Shared constants for the F-stage PC unit: reset/handler addresses,
// instruction-memory window, exception codes and the next-PC select encoding.
package fetch_pc_unit_pkg;

    localparam logic [31:0] RESET_PC    = 32'h0000_3000;
    localparam logic [31:0] EXC_HANDLER = 32'h0000_4180;
    localparam logic [31:0] IM_BASE     = 32'h0000_3000;
    localparam int          IM_WORDS    = 4096;

    // Exception codes, shared with CP0 and the later pipeline stages
    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    // Next-PC source, listed from highest to lowest priority
    typedef enum logic [2:0] {
        NPC_EXC  = 3'd0,
        NPC_ERET = 3'd1,
        NPC_HOLD = 3'd2,
        NPC_BR   = 3'd3,
        NPC_SEQ  = 3'd4
    } npc_sel_e;

endpackage

// File: rtl/fetch_pc_unit_addr_check.sv
// fetch_addr_check: alignment and range check of a word fetch/load address.
// An out-of-window or misaligned address is flagged, and the memory address
// is clamped to the window base so memory is always read in range.
module fetch_addr_check
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] BASE  = IM_BASE,
    parameter int          WORDS = IM_WORDS
) (
    input  logic [31:0] addr_i,
    output logic        addr_err_o,
    output logic [31:0] im_addr_o
);

    // 33-bit limit so a window ending exactly at 2^32 does not wrap
    localparam logic [32:0] LIMIT = {1'b0, BASE} + (33'(WORDS) << 2);

    logic misaligned;
    logic below;
    logic above;

    assign misaligned = (addr_i[1:0] != 2'b00);
    assign below      = (addr_i < BASE);
    assign above      = ({1'b0, addr_i} >= LIMIT);

    // Flag the error and steer memory to a safe address when flagged
    always_comb begin
        addr_err_o = misaligned | below | above;
        im_addr_o  = addr_err_o ? BASE : addr_i;
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: F-stage program counter of the 5-stage MIPS pipeline.
// Selects next PC (exception > eret > stall > branch > sequential), drives the
// instruction-memory address and flags AdEL / delay-slot status for F/D.
// Optional macro FETCH_PERF_EN adds fetch_cnt / stall_cnt performance counters.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] P_RESET_PC    = RESET_PC,
    parameter logic [31:0] P_EXC_HANDLER = EXC_HANDLER,
    parameter logic [31:0] P_IM_BASE     = IM_BASE,
    parameter int          P_IM_WORDS    = IM_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        d_is_branch,
    input  logic        req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] pc,
    output logic [31:0] im_pc,
    output logic [4:0]  f_exc_code,
    output logic        f_kill,
`ifdef FETCH_PERF_EN
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt,
`endif
    output logic        f_bd
);

    npc_sel_e    sel;
    logic [31:0] pc_q, pc_d;
    logic        redirect_q, redirect_d;
    logic        addr_err;

    // Resolve the next-PC source by priority
    always_comb begin
        if (req)           sel = NPC_EXC;
        else if (eret)     sel = NPC_ERET;
        else if (stall)    sel = NPC_HOLD;
        else if (br_taken) sel = NPC_BR;
        else               sel = NPC_SEQ;
    end

    // Next PC and redirect flag; redirect stays set across stalls so the first
    // word actually fetched after a flush is never treated as a delay slot
    always_comb begin
        pc_d       = pc_q;
        redirect_d = redirect_q;
        case (sel)
            NPC_EXC:  begin pc_d = P_EXC_HANDLER; redirect_d = 1'b1; end
            NPC_ERET: begin pc_d = epc;           redirect_d = 1'b1; end
            NPC_HOLD: begin pc_d = pc_q;          redirect_d = redirect_q; end
            NPC_BR:   begin pc_d = br_target;     redirect_d = 1'b0; end
            default:  begin pc_d = pc_q + 32'd4;  redirect_d = 1'b0; end
        endcase
    end

    // PC and redirect state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= P_RESET_PC;
            redirect_q <= 1'b1;
        end else begin
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
        end
    end

    fetch_addr_check #(
        .BASE  (P_IM_BASE),
        .WORDS (P_IM_WORDS)
    ) u_addr_check (
        .addr_i     (pc_q),
        .addr_err_o (addr_err),
        .im_addr_o  (im_pc)
    );

    assign pc         = pc_q;
    assign f_exc_code = addr_err ? EXC_ADEL : EXC_NONE;
    assign f_kill     = addr_err;
    assign f_bd       = d_is_branch & ~redirect_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    // Count fetch-advancing edges and pure stall edges (both wrap)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            if (sel != NPC_HOLD) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            else                 stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios plus a randomized
// run against a behavioural next-PC model.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, br_taken, d_is_branch, req, eret;
    logic [31:0] br_target, epc;
    logic [31:0] pc, im_pc;
    logic [4:0]  f_exc_code;
    logic        f_kill, f_bd;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt, stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] mpc;
    logic        mflush;   // last PC change was an exception/eret redirect

    always #5 clk = ~clk;

    fetch_pc_unit dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .d_is_branch (d_is_branch),
        .req         (req),
        .eret        (eret),
        .epc         (epc),
        .pc          (pc),
        .im_pc       (im_pc),
        .f_exc_code  (f_exc_code),
        .f_kill      (f_kill),
`ifdef FETCH_PERF_EN
        .fetch_cnt   (fetch_cnt),
        .stall_cnt   (stall_cnt),
`endif
        .f_bd        (f_bd)
    );

    // fetch window is 0x3000 .. 0x6FFC, word aligned
    function automatic logic bad_addr(input logic [31:0] a);
        longint unsigned v;
        v = longint'(a);
        return (v % 4 != 0) || (v < 64'h3000) || (v >= 64'h3000 + 4 * 4096);
    endfunction

    // one clock edge: model follows the architectural rules, then settle
    task automatic tick();
        @(posedge clk);
        if (req)           begin mpc = 32'h4180;   mflush = 1'b1; end
        else if (eret)     begin mpc = epc;        mflush = 1'b1; end
        else if (stall)    begin end
        else if (br_taken) begin mpc = br_target;  mflush = 1'b0; end
        else               begin mpc = mpc + 32'd4; mflush = 1'b0; end
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; br_taken = 0; br_target = 0; d_is_branch = 0;
        req = 0; eret = 0; epc = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mpc = 32'h3000; mflush = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        d_is_branch = 1'b1;
        mpc = 32'h3000; mflush = 1'b1;
        #12;
        checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h3000); end
        checks++; if (im_pc !== 32'h3000) begin errors++; $display("FAIL reset_im_pc got=%h exp=%h", im_pc, 32'h3000); end
        checks++; if (f_bd !== 1'b0) begin errors++; $display("FAIL reset_f_bd got=%b exp=0", f_bd); end
        checks++; if (f_exc_code !== 5'd0 || f_kill !== 1'b0) begin errors++; $display("FAIL reset_exc got=%0d/%b exp=0/0", f_exc_code, f_kill); end
        d_is_branch = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (pc !== 32'h3000 + 32'(4 * i)) begin errors++; $display("FAIL seq_pc%0d got=%h exp=%h", i, pc, 32'h3000 + 32'(4 * i)); end
        end
    endtask

    task automatic test_stall_branch();
        tick();
        checks++; if (pc !== 32'h3010) begin errors++; $display("FAIL pre_stall_pc got=%h exp=%h", pc, 32'h3010); end
        stall = 1; br_taken = 1; br_target = 32'h3100;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (pc !== 32'h3010) begin errors++; $display("FAIL stall_hold%0d got=%h exp=%h", i, pc, 32'h3010); end
        end
        stall = 0;
        tick();
        checks++; if (pc !== 32'h3100) begin errors++; $display("FAIL branch_pc got=%h exp=%h", pc, 32'h3100); end
        d_is_branch = 1; #1;
        checks++; if (f_bd !== 1'b1) begin errors++; $display("FAIL bd_after_branch got=%b exp=1", f_bd); end
        idle_inputs();
    endtask

    task automatic test_req_priority();
        br_taken = 1; br_target = 32'h3200;
        tick();
        checks++; if (pc !== 32'h3200) begin errors++; $display("FAIL br3200 got=%h exp=%h", pc, 32'h3200); end
        req = 1; stall = 1; br_taken = 1; br_target = 32'h3300; d_is_branch = 1;
        tick();
        checks++; if (pc !== 32'h4180) begin errors++; $display("FAIL req_pc got=%h exp=%h", pc, 32'h4180); end
        checks++; if (f_bd !== 1'b0) begin errors++; $display("FAIL req_bd got=%b exp=0", f_bd); end
        req = 0; stall = 1; br_taken = 0;
        tick();
        checks++; if (pc !== 32'h4180 || f_bd !== 1'b0) begin errors++; $display("FAIL req_stall got=%h/%b exp=%h/0", pc, f_bd, 32'h4180); end
        stall = 0;
        tick();
        checks++; if (pc !== 32'h4184) begin errors++; $display("FAIL req_next got=%h exp=%h", pc, 32'h4184); end
        checks++; if (f_bd !== 1'b1) begin errors++; $display("FAIL bd_follow1 got=%b exp=1", f_bd); end
        d_is_branch = 0; #1;
        checks++; if (f_bd !== 1'b0) begin errors++; $display("FAIL bd_follow0 got=%b exp=0", f_bd); end
        idle_inputs();
    endtask

    task automatic test_eret();
        eret = 1; epc = 32'h3344; stall = 1;
        tick();
        checks++; if (pc !== 32'h3344) begin errors++; $display("FAIL eret_pc got=%h exp=%h", pc, 32'h3344); end
        stall = 0; req = 1;
        tick();
        checks++; if (pc !== 32'h4180) begin errors++; $display("FAIL req_eret got=%h exp=%h", pc, 32'h4180); end
        idle_inputs();
    endtask

    task automatic test_addr_err();
        logic [31:0] tgt [4];
        logic        err [4];
        tgt[0] = 32'h3002; err[0] = 1;
        tgt[1] = 32'h7000; err[1] = 1;
        tgt[2] = 32'h6FFC; err[2] = 0;
        tgt[3] = 32'h2FFC; err[3] = 1;
        for (int i = 0; i < 4; i++) begin
            br_taken = 1; br_target = tgt[i];
            tick();
            checks++;
            if (pc !== tgt[i] || f_exc_code !== (err[i] ? 5'd4 : 5'd0) || f_kill !== err[i] ||
                im_pc !== (err[i] ? 32'h3000 : tgt[i])) begin
                errors++;
                $display("FAIL adel_%h got pc=%h exc=%0d kill=%b im=%h exp err=%b", tgt[i], pc, f_exc_code, f_kill, im_pc, err[i]);
            end
        end
        br_target = 32'hFFFF_FFFC;
        tick();
        br_taken = 0;
        tick();
        checks++; if (pc !== 32'h0 || f_exc_code !== 5'd4 || im_pc !== 32'h3000) begin errors++; $display("FAIL wrap got pc=%h exc=%0d im=%h exp 0/4/3000", pc, f_exc_code, im_pc); end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        br_taken = 1; br_target = 32'h3500;
        tick();
        checks++; if (pc !== 32'h3500) begin errors++; $display("FAIL pre_async got=%h exp=%h", pc, 32'h3500); end
        br_taken = 0;
        #2 reset = 1;
        mpc = 32'h3000; mflush = 1'b1;
        #1;
        checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL async_reset got=%h exp=%h", pc, 32'h3000); end
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_random();
        logic [31:0] r;
        for (int n = 0; n < 600; n++) begin
            stall       = ($urandom % 4) == 0;
            req         = ($urandom % 16) == 0;
            eret        = ($urandom % 12) == 0;
            br_taken    = ($urandom % 3) == 0;
            d_is_branch = $urandom % 2;
            r = $urandom % 8;
            if (r == 0)      br_target = $urandom;
            else if (r == 1) br_target = ($urandom % 2) ? 32'h6FFC : 32'h7000;
            else             br_target = 32'h3000 + 32'($urandom % 4096) * 4;
            epc = 32'h3000 + 32'($urandom % 4096) * 4;
            tick();
            checks++;
            if (pc !== mpc || f_bd !== (d_is_branch & ~mflush) ||
                f_kill !== bad_addr(mpc) || f_exc_code !== (bad_addr(mpc) ? 5'd4 : 5'd0) ||
                im_pc !== (bad_addr(mpc) ? 32'h3000 : mpc)) begin
                errors++;
                $display("FAIL rand%0d got pc=%h bd=%b kill=%b exc=%0d im=%h exp pc=%h bd=%b err=%b",
                         n, pc, f_bd, f_kill, f_exc_code, im_pc, mpc, d_is_branch & ~mflush, bad_addr(mpc));
            end
        end
        idle_inputs();
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        idle_inputs();
        do_reset();
        checks++; if (fetch_cnt !== 0 || stall_cnt !== 0) begin errors++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", fetch_cnt, stall_cnt); end
        for (int i = 0; i < 5; i++) tick();
        stall = 1;
        for (int i = 0; i < 2; i++) tick();
        stall = 0;
        checks++; if (fetch_cnt !== 32'd5) begin errors++; $display("FAIL fetch_cnt got=%0d exp=5", fetch_cnt); end
        checks++; if (stall_cnt !== 32'd2) begin errors++; $display("FAIL stall_cnt got=%0d exp=2", stall_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_stall_branch();
        test_req_priority();
        test_eret();
        test_addr_err();
        test_async_reset();
        test_random();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
